// File: rtl/cache_fill_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_arb_pkg : shared types and geometry for cache_fill_arbiter      |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2,
    WRITE  = 2'd3
  } arb_state_t;

  localparam int BLOCK_WORDS       = 8;
  localparam int WORD_BYTES        = 2;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int CNT_W             = 3;
  localparam int ADDR_W            = 16;

  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + ADDR_W'(idx) * ADDR_W'(WORD_BYTES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_fill_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_fill_arbiter_if : cache request / fill / main-memory bundle     |
// | Optional: CACHE_FILL_PERF_CNT_EN adds fill-count outputs              |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface cache_fill_arbiter_if;
  logic        icache_miss_detected;
  logic [15:0] icache_miss_addr;
  logic        dcache_miss_detected;
  logic [15:0] dcache_miss_addr;
  logic        dcache_write_enable;
  logic [15:0] dcache_write_addr;
  logic [15:0] dcache_write_data;
  logic [15:0] icache_fill_data;
  logic [15:0] icache_fill_addr;
  logic [15:0] dcache_fill_data;
  logic [15:0] dcache_fill_addr;
  logic        icache_write_data_array;
  logic        icache_write_tag_array;
  logic        dcache_write_data_array;
  logic        dcache_write_tag_array;
  logic        dcache_write_done;
  logic [15:0] mainmem_addr;
  logic [15:0] mainmem_write_data;
  logic        mainmem_enable;
  logic        mainmem_wr;
  logic [15:0] mainmem_read_data;
  logic        mainmem_data_valid;
  logic        stall;
`ifdef CACHE_FILL_PERF_CNT_EN
  logic [15:0] icache_fill_count;
  logic [15:0] dcache_fill_count;
`endif

  modport slave (
    input  icache_miss_detected, icache_miss_addr,
    input  dcache_miss_detected, dcache_miss_addr,
    input  dcache_write_enable, dcache_write_addr, dcache_write_data,
    input  mainmem_read_data, mainmem_data_valid,
    output icache_fill_data, icache_fill_addr, dcache_fill_data, dcache_fill_addr,
    output icache_write_data_array, icache_write_tag_array,
    output dcache_write_data_array, dcache_write_tag_array,
    output dcache_write_done,
    output mainmem_addr, mainmem_write_data, mainmem_enable, mainmem_wr,
    output stall
`ifdef CACHE_FILL_PERF_CNT_EN
    , output icache_fill_count, output dcache_fill_count
`endif
  );

  modport master (
    output icache_miss_detected, icache_miss_addr,
    output dcache_miss_detected, dcache_miss_addr,
    output dcache_write_enable, dcache_write_addr, dcache_write_data,
    output mainmem_read_data, mainmem_data_valid,
    input  icache_fill_data, icache_fill_addr, dcache_fill_data, dcache_fill_addr,
    input  icache_write_data_array, icache_write_tag_array,
    input  dcache_write_data_array, dcache_write_tag_array,
    input  dcache_write_done,
    input  mainmem_addr, mainmem_write_data, mainmem_enable, mainmem_wr,
    input  stall
`ifdef CACHE_FILL_PERF_CNT_EN
    , input icache_fill_count, input dcache_fill_count
`endif
  );
endinterface
`default_nettype wire

// File: rtl/cache_fill_arbiter_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fill_word_counter : 3-bit block word counter with terminal flag       |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module fill_word_counter
  import cache_arb_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             clear,
  input  wire logic             enable,
  output logic      [CNT_W-1:0] count,
  output logic                  terminal
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == CNT_W'(BLOCK_WORDS - 1));

endmodule
`default_nettype wire

// File: rtl/cache_fill_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_fill_arbiter : shares main memory between I/D fills and stores  |
// | Optional: CACHE_FILL_PERF_CNT_EN adds saturating fill counters        |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module cache_fill_arbiter
  import cache_arb_pkg::*;
(
  input wire logic clk,
  input wire logic rst,
  cache_fill_arbiter_if.slave bus
);

  arb_state_t              state;
  logic       [ADDR_W-1:0] base;
  logic                    issuing;
  logic                    mem_enable;
  logic                    mem_wr;
  logic       [ADDR_W-1:0] mem_addr;
  logic       [15:0]       mem_wdata;
  logic                    write_done;

  logic                    in_fill;
  logic                    issue_en;
  logic                    recv_en;
  logic       [CNT_W-1:0]  issue_cnt;
  logic       [CNT_W-1:0]  recv_cnt;
  logic                    issue_tc;
  logic                    recv_tc;
  logic                    i_strobe;
  logic                    d_strobe;

  assign in_fill  = (state == FILL_I) || (state == FILL_D);
  assign issue_en = in_fill && issuing;
  assign recv_en  = in_fill && bus.mainmem_data_valid && !rst;

  fill_word_counter u_issue_cnt (
    .clk      (clk),
    .clear    (rst),
    .enable   (issue_en),
    .count    (issue_cnt),
    .terminal (issue_tc)
  );

  fill_word_counter u_recv_cnt (
    .clk      (clk),
    .clear    (rst),
    .enable   (recv_en),
    .count    (recv_cnt),
    .terminal (recv_tc)
  );

  // Memory-port outputs are set up one edge ahead so they are registered in the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      issuing    <= 1'b0;
      mem_enable <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      write_done <= 1'b0;
    end else begin
      mem_enable <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      write_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.dcache_miss_detected) begin
            state      <= FILL_D;
            base       <= block_base(bus.dcache_miss_addr);
            issuing    <= 1'b1;
            mem_enable <= 1'b1;
            mem_addr   <= block_base(bus.dcache_miss_addr);
          end else if (bus.dcache_write_enable) begin
            state      <= WRITE;
            mem_enable <= 1'b1;
            mem_wr     <= 1'b1;
            mem_addr   <= bus.dcache_write_addr;
            mem_wdata  <= bus.dcache_write_data;
            write_done <= 1'b1;
          end else if (bus.icache_miss_detected) begin
            state      <= FILL_I;
            base       <= block_base(bus.icache_miss_addr);
            issuing    <= 1'b1;
            mem_enable <= 1'b1;
            mem_addr   <= block_base(bus.icache_miss_addr);
          end
        end
        FILL_I, FILL_D: begin
          if (issuing && !issue_tc) begin
            mem_enable <= 1'b1;
            mem_addr   <= word_addr(base, issue_cnt + 3'd1);
          end
          if (issuing && issue_tc) begin
            issuing <= 1'b0;
          end
          if (recv_en && recv_tc) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_strobe = recv_en && (state == FILL_I);
  assign d_strobe = recv_en && (state == FILL_D);

  assign bus.icache_write_data_array = i_strobe;
  assign bus.icache_write_tag_array  = i_strobe && recv_tc;
  assign bus.icache_fill_data        = i_strobe ? bus.mainmem_read_data : '0;
  assign bus.icache_fill_addr        = i_strobe ? word_addr(base, recv_cnt) : '0;
  assign bus.dcache_write_data_array = d_strobe;
  assign bus.dcache_write_tag_array  = d_strobe && recv_tc;
  assign bus.dcache_fill_data        = d_strobe ? bus.mainmem_read_data : '0;
  assign bus.dcache_fill_addr        = d_strobe ? word_addr(base, recv_cnt) : '0;

  assign bus.mainmem_enable     = mem_enable;
  assign bus.mainmem_wr         = mem_wr;
  assign bus.mainmem_addr       = mem_addr;
  assign bus.mainmem_write_data = mem_wdata;
  assign bus.dcache_write_done  = write_done;

  assign bus.stall = (state != IDLE) || bus.icache_miss_detected || bus.dcache_miss_detected;

`ifdef CACHE_FILL_PERF_CNT_EN
  logic [15:0] icache_fill_total;
  logic [15:0] dcache_fill_total;

  always_ff @(posedge clk) begin
    if (rst) begin
      icache_fill_total <= '0;
      dcache_fill_total <= '0;
    end else begin
      if (bus.icache_write_tag_array && (icache_fill_total != 16'hFFFF)) begin
        icache_fill_total <= icache_fill_total + 16'd1;
      end
      if (bus.dcache_write_tag_array && (dcache_fill_total != 16'hFFFF)) begin
        dcache_fill_total <= dcache_fill_total + 16'd1;
      end
    end
  end

  assign bus.icache_fill_count = icache_fill_total;
  assign bus.dcache_fill_count = dcache_fill_total;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cache_fill_arbiter : directed checks of fills, stores and reset    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cache_fill_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  cache_fill_arbiter_if bus ();

  cache_fill_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Main memory: fixed 4-cycle read latency, data = address ^ A5A5, shares rst.
  logic [3:0]  pipe_v;
  logic [15:0] pipe_a [4];
  logic        inject_v = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < 4; i++) pipe_a[i] <= '0;
    end else begin
      pipe_v <= {pipe_v[2:0], bus.mainmem_enable & ~bus.mainmem_wr};
      pipe_a[0] <= bus.mainmem_addr;
      for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
    end
  end

  assign bus.mainmem_data_valid = pipe_v[3] | inject_v;
  assign bus.mainmem_read_data  = inject_v ? 16'hDEAD : (pipe_a[3] ^ 16'hA5A5);

  // Activity log
  logic [15:0] rd_addr[$], ifill_addr[$], ifill_data[$], dfill_addr[$], dfill_data[$];
  logic [15:0] wr_addr[$], wr_data[$];
  int rd_cyc[$];
  int wr_cyc, itag_n, dtag_n, dtag_cyc, done_n, overlap_n, bad_n, first_i_cyc, last_d_cyc;

  task automatic clear_log();
    rd_addr.delete(); rd_cyc.delete(); ifill_addr.delete(); ifill_data.delete();
    dfill_addr.delete(); dfill_data.delete(); wr_addr.delete(); wr_data.delete();
    wr_cyc = -1; itag_n = 0; dtag_n = 0; dtag_cyc = -1; done_n = 0;
    overlap_n = 0; bad_n = 0; first_i_cyc = -1; last_d_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (bus.mainmem_enable && !bus.mainmem_wr) begin
      rd_addr.push_back(bus.mainmem_addr); rd_cyc.push_back(cyc);
    end
    if (bus.mainmem_enable && bus.mainmem_wr) begin
      wr_addr.push_back(bus.mainmem_addr); wr_data.push_back(bus.mainmem_write_data); wr_cyc = cyc;
    end
    if (bus.icache_write_data_array) begin
      ifill_addr.push_back(bus.icache_fill_addr); ifill_data.push_back(bus.icache_fill_data);
      if (first_i_cyc < 0) first_i_cyc = cyc;
    end else if (bus.icache_fill_data != 0 || bus.icache_fill_addr != 0 || bus.icache_write_tag_array) begin
      bad_n++;
    end
    if (bus.dcache_write_data_array) begin
      dfill_addr.push_back(bus.dcache_fill_addr); dfill_data.push_back(bus.dcache_fill_data);
      last_d_cyc = cyc;
    end else if (bus.dcache_fill_data != 0 || bus.dcache_fill_addr != 0 || bus.dcache_write_tag_array) begin
      bad_n++;
    end
    if (bus.icache_write_tag_array) itag_n++;
    if (bus.dcache_write_tag_array) begin dtag_n++; dtag_cyc = cyc; end
    if (bus.icache_write_data_array && bus.dcache_write_data_array) overlap_n++;
    if (bus.dcache_write_done) done_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_block(input string tag, input bit is_d, input logic [15:0] base);
    int n;
    logic [15:0] a, d, ea;
    n = is_d ? dfill_addr.size() : ifill_addr.size();
    check({tag, " words"}, n, 8);
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        a  = is_d ? dfill_addr[i] : ifill_addr[i];
        d  = is_d ? dfill_data[i] : ifill_data[i];
        ea = base + 16'(2 * i);
        check($sformatf("%s addr%0d", tag, i), a, ea);
        check($sformatf("%s data%0d", tag, i), d, ea ^ 16'hA5A5);
      end
    end
  endtask

  // Acts as the caches: drops each request once the arbiter has completed it.
  task automatic service(input string tag, input int max_cycles);
    bit fin, drop_i, drop_d, drop_w;
    fin = 1'b0;
    for (int n = 0; n < max_cycles && !fin; n++) begin
      @(negedge clk); #1;
      if (!bus.icache_miss_detected && !bus.dcache_miss_detected &&
          !bus.dcache_write_enable && !bus.stall) begin
        fin = 1'b1;
      end else begin
        drop_i = bus.icache_write_tag_array;
        drop_d = bus.dcache_write_tag_array;
        drop_w = bus.dcache_write_done;
        @(posedge clk); #1;
        if (drop_i) bus.icache_miss_detected = 1'b0;
        if (drop_d) bus.dcache_miss_detected = 1'b0;
        if (drop_w) bus.dcache_write_enable  = 1'b0;
      end
    end
    check({tag, " completes"}, fin, 1'b1);
  endtask

  task automatic do_fill(input bit is_d, input logic [15:0] a);
    @(posedge clk); #1;
    if (is_d) begin bus.dcache_miss_addr = a; bus.dcache_miss_detected = 1'b1; end
    else      begin bus.icache_miss_addr = a; bus.icache_miss_detected = 1'b1; end
    service("fill", 60);
  endtask

  int k;

  initial begin
    bus.icache_miss_detected = 1'b0; bus.icache_miss_addr  = '0;
    bus.dcache_miss_detected = 1'b0; bus.dcache_miss_addr  = '0;
    bus.dcache_write_enable  = 1'b0; bus.dcache_write_addr = '0;
    bus.dcache_write_data    = '0;
    clear_log();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst stall", bus.stall, 1'b0);
    check("rst mem_en", bus.mainmem_enable, 1'b0);
    check("rst mem_wr", bus.mainmem_wr, 1'b0);
    check("rst mem_addr", bus.mainmem_addr, 16'h0);
    check("rst done", bus.dcache_write_done, 1'b0);
    check("rst strobes", {bus.icache_write_data_array, bus.icache_write_tag_array,
                          bus.dcache_write_data_array, bus.dcache_write_tag_array}, 4'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Stray valids while idle must not strobe nor advance the receive count.
    inject_v = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle valid strobe", {bus.icache_write_data_array, bus.dcache_write_data_array}, 2'b00);
    end
    @(posedge clk); #1 inject_v = 1'b0;

    // D-miss at 1236, latency 4
    clear_log();
    k = cyc;
    bus.dcache_miss_addr = 16'h1236; bus.dcache_miss_detected = 1'b1;
    service("t1", 60);
    check("t1 idle at", cyc - k, 13);
    check("t1 reads", rd_addr.size(), 8);
    for (int i = 0; i < 8; i++) if (i < rd_addr.size())
      check($sformatf("t1 rd%0d", i), rd_addr[i], 16'h1230 + 16'(2 * i));
    if (rd_cyc.size() == 8) begin
      check("t1 first issue", rd_cyc[0] - k, 1);
      check("t1 last issue", rd_cyc[7] - k, 8);
    end
    check_block("t1", 1'b1, 16'h1230);
    check("t1 tag cnt", dtag_n, 1);
    check("t1 tag cyc", dtag_cyc - k, 12);
    check("t1 bad", bad_n, 0);

    // Simultaneous I and D misses
    clear_log();
    @(posedge clk); #1;
    bus.icache_miss_addr = 16'h3458; bus.icache_miss_detected = 1'b1;
    bus.dcache_miss_addr = 16'h5A5F; bus.dcache_miss_detected = 1'b1;
    service("t2", 100);
    check_block("t2 d", 1'b1, 16'h5A50);
    check_block("t2 i", 1'b0, 16'h3450);
    check("t2 d before i", (last_d_cyc >= 0) && (first_i_cyc > last_d_cyc), 1'b1);
    check("t2 overlap", overlap_n, 0);
    check("t2 tags", {itag_n[7:0], dtag_n[7:0]}, 16'h0101);
    check("t2 bad", bad_n, 0);

    // Plain store
    clear_log();
    @(posedge clk); #1;
    k = cyc;
    bus.dcache_write_addr = 16'h0040; bus.dcache_write_data = 16'hBEEF; bus.dcache_write_enable = 1'b1;
    service("t3", 20);
    check("t3 writes", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("t3 addr", wr_addr[0], 16'h0040);
      check("t3 data", wr_data[0], 16'hBEEF);
    end
    check("t3 wr cyc", wr_cyc - k, 1);
    check("t3 done", done_n, 1);
    check("t3 reads", rd_addr.size(), 0);
    check("t3 stall", bus.stall, 1'b0);

    // Store that misses
    clear_log();
    @(posedge clk); #1;
    bus.dcache_miss_addr  = 16'h0040; bus.dcache_miss_detected = 1'b1;
    bus.dcache_write_addr = 16'h0040; bus.dcache_write_data    = 16'h1234;
    bus.dcache_write_enable = 1'b1;
    service("t4", 60);
    check_block("t4", 1'b1, 16'h0040);
    check("t4 writes", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("t4 addr", wr_addr[0], 16'h0040);
      check("t4 data", wr_data[0], 16'h1234);
    end
    check("t4 done", done_n, 1);
    check("t4 write after fill", wr_cyc - dtag_cyc, 2);

    // Reset on the 5th fill cycle, then refill
    clear_log();
    @(posedge clk); #1;
    k = cyc;
    bus.dcache_miss_addr = 16'h7788; bus.dcache_miss_detected = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5 idle mem_en", bus.mainmem_enable, 1'b0);
    check("t5 no tag", dtag_n, 0);
    check("t5 no fill", dfill_addr.size(), 0);
    check("t5 bad", bad_n, 0);
    @(posedge clk); #1;
    clear_log();
    service("t5 refill", 60);
    check_block("t5", 1'b1, 16'h7780);
    check("t5 tag", dtag_n, 1);

`ifdef CACHE_FILL_PERF_CNT_EN
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    do_fill(1'b0, 16'h1000); do_fill(1'b0, 16'h1010); do_fill(1'b0, 16'h1020);
    do_fill(1'b1, 16'h2000); do_fill(1'b1, 16'h2010);
    check("perf i", bus.icache_fill_count, 16'd3);
    check("perf d", bus.dcache_fill_count, 16'd2);
    force dut.icache_fill_total = 16'hFFFF;
    @(posedge clk); #1 release dut.icache_fill_total;
    do_fill(1'b0, 16'h1030);
    check("perf sat", bus.icache_fill_count, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
